// File: rtl/rd_return_path.sv
// -----------------------------------------------------------------------------
// rd_return_path
//
// Read-return side of the DDR SDRAM controller. The block records the
// bank/row/col of every READ issued to the DRAM, in issue order, in a tag
// FIFO. It collects DQ beats from the PHY read path and packs each pair of
// beats into a 32-bit word in a data FIFO. Each word is returned to the
// requester together with the original byte address, which is rebuilt from
// the matching tag.
//
// Ports
//   clk            controller clock; all logic is rising-edge
//   rst_n          asynchronous active-low reset
//   rd_issue_valid scheduler issues a READ this cycle
//   rd_issue_ready there is room for another outstanding read
//   rd_issue_bank  bank of the issued READ
//   rd_issue_row   row of the issued READ
//   rd_issue_col   column of the issued READ
//   phy_rd_valid   one read-data beat is valid (cannot be stalled)
//   phy_rd_data    read-data beat
//   rsp_valid      a read response is available
//   rsp_ready      requester accepts the response
//   rsp_rdata      read data, {beat1, beat0}
//   rsp_addr       reconstructed request address
//   outstanding    reads issued but not yet returned (tag FIFO count)
//   err_orphan     1-cycle pulse: a beat arrived with no read awaiting data
// -----------------------------------------------------------------------------
module rd_return_path #(
    parameter int DEPTH    = 8,
    parameter int DQ_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_issue_valid,
    output logic                     rd_issue_ready,
    input  logic [2:0]               rd_issue_bank,
    input  logic [13:0]              rd_issue_row,
    input  logic [9:0]               rd_issue_col,
    input  logic                     phy_rd_valid,
    input  logic [DQ_WIDTH-1:0]      phy_rd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic [31:0]              rsp_addr,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_orphan
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int TAG_W = 27;

    // Tag layout: {bank[2:0], row[13:0], col[9:0]}
    function automatic logic [31:0] make_addr(input logic [TAG_W-1:0] tag);
        return {3'b000, tag[23:10], tag[26:24], tag[9:0], 2'b00};
    endfunction

    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PW-1:0]    tag_wr_ptr;
    logic [PW-1:0]    tag_rd_ptr;
    logic [CW-1:0]    tag_count;

    logic [31:0]      data_mem [DEPTH];
    logic [PW-1:0]    data_wr_ptr;
    logic [PW-1:0]    data_rd_ptr;
    logic [CW-1:0]    data_count;

    logic                phase;
    logic [DQ_WIDTH-1:0] low_half;

    logic             issue_fire;
    logic             rsp_pop;
    logic [CW-1:0]    pending;
    logic             beat_lo;
    logic             word_done;
    logic             orphan;
    logic [31:0]      new_word;
    logic [PW-1:0]    tag_rd_ptr_nxt;
    logic [PW-1:0]    data_rd_ptr_nxt;
    logic [CW-1:0]    data_left;
    logic [CW-1:0]    data_count_nxt;
    logic [31:0]      head_rdata_nxt;
    logic [TAG_W-1:0] head_tag_nxt;

    always_comb begin
        rd_issue_ready  = (tag_count < CW'(DEPTH));
        issue_fire      = rd_issue_valid & rd_issue_ready;
        rsp_valid       = (data_count != '0);
        rsp_pop         = rsp_valid & rsp_ready;

        // Reads that have a tag but whose data word has not started yet
        // (a half-assembled word is not counted; it only exists in phase 1).
        pending         = tag_count - data_count;
        beat_lo         = phy_rd_valid & ~phase & (pending != '0);
        orphan          = phy_rd_valid & ~phase & (pending == '0);
        word_done       = phy_rd_valid & phase;
        new_word        = {phy_rd_data, low_half};

        tag_rd_ptr_nxt  = tag_rd_ptr + PW'(rsp_pop);
        data_rd_ptr_nxt = data_rd_ptr + PW'(rsp_pop);
        data_left       = data_count - CW'(rsp_pop);
        data_count_nxt  = data_left + CW'(word_done);

        // Next head of the data FIFO: when the FIFO is (or becomes) empty the
        // word being completed this cycle is the next head, so bypass it.
        // The matching tag always already sits in the tag FIFO, because a
        // word can only start while its tag is pending and tags are popped
        // only together with completed words.
        head_rdata_nxt  = (data_left == '0) ? new_word : data_mem[data_rd_ptr_nxt];
        head_tag_nxt    = tag_mem[tag_rd_ptr_nxt];

        outstanding     = tag_count;
    end

    // Control state and registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr_ptr  <= '0;
            tag_rd_ptr  <= '0;
            tag_count   <= '0;
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
            data_count  <= '0;
            phase       <= 1'b0;
            err_orphan  <= 1'b0;
            rsp_rdata   <= '0;
            rsp_addr    <= '0;
        end else begin
            if (issue_fire) begin
                tag_wr_ptr <= tag_wr_ptr + 1'b1;
            end
            tag_rd_ptr <= tag_rd_ptr_nxt;
            tag_count  <= tag_count + CW'(issue_fire) - CW'(rsp_pop);

            if (beat_lo) begin
                phase <= 1'b1;
            end else if (word_done) begin
                phase <= 1'b0;
            end

            if (word_done) begin
                data_wr_ptr <= data_wr_ptr + 1'b1;
            end
            data_rd_ptr <= data_rd_ptr_nxt;
            data_count  <= data_count_nxt;

            err_orphan  <= orphan;

            // Outputs follow the FIFO heads; they only change on a pop or when
            // an empty FIFO receives a word, so they hold while stalled.
            if (data_count_nxt != '0) begin
                rsp_rdata <= head_rdata_nxt;
                rsp_addr  <= make_addr(head_tag_nxt);
            end
        end
    end

    // Storage: FIFO arrays and the low-half beat latch carry no reset
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            tag_mem[tag_wr_ptr] <= {rd_issue_bank, rd_issue_row, rd_issue_col};
        end
        if (word_done) begin
            data_mem[data_wr_ptr] <= new_word;
        end
        if (beat_lo) begin
            low_half <= phy_rd_data;
        end
    end

endmodule
